// File: rtl/tiny_cpu_pkg.sv
// Shared types and constants for the tiny CPU fetch stage.
// fetch_entry_t is the default-width (8-bit pc) entry layout; the fetch top sizes pc from PC_W.
package tiny_cpu_pkg;

  localparam int OP_W     = 8;
  localparam int LONG_BIT = 7;
  localparam int PC_W_DEF = 8;

  typedef enum logic {S_OP, S_IMM} fetch_state_t;

  typedef struct packed {
    logic [OP_W-1:0]     op;
    logic [OP_W-1:0]     imm;
    logic [PC_W_DEF-1:0] pc;
  } fetch_entry_t;

  function automatic int entry_width(input int pc_w);
    return 2 * OP_W + pc_w;
  endfunction

endpackage

// File: rtl/tiny_cpu_sync_fifo.sv
// Generic synchronous show-ahead FIFO; dout is the head entry.
// Storage is zeroed on clear and popped slots are zeroed, so an empty FIFO reads 0.
module tiny_cpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // Zero the popped slot first; push and pop never share a slot (empty/full gate them).
      if (do_pop) begin
        mem[rd_ptr] <= '0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tiny_cpu_fetch.sv
// Byte-serial instruction fetch: assembles 1/2-byte instructions into a show-ahead FIFO.
// Optional retired-instruction counter enabled by TINY_CPU_FETCH_STATS_EN.
//
// state | meaning
// S_OP  | waiting for an opcode byte
// S_IMM | two-byte opcode held, waiting for its immediate byte
module tiny_cpu_fetch
  import tiny_cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      in_byte,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic [PC_W-1:0] flush_pc,
  output logic [PC_W-1:0] fetch_pc,
  output logic [7:0]      ins_op,
  output logic [7:0]      ins_imm,
  output logic [PC_W-1:0] ins_pc,
  output logic            ins_valid,
  input  logic            ins_ready,
  output logic [15:0]     ins_count
);

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [OP_W-1:0] imm;
    logic [PC_W-1:0] pc;
  } entry_t;

  fetch_state_t          state;
  logic [OP_W-1:0]       held_op;
  logic [PC_W-1:0]       held_pc;
  entry_t                push_entry;
  entry_t                head;
  logic                  clear;
  logic                  byte_acc;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [$clog2(DEPTH):0] level_unused;

  assign clear     = rst || flush;
  assign in_ready  = !fifo_full && !clear;
  assign byte_acc  = in_valid && in_ready;
  assign pop       = ins_ready && !fifo_empty && !clear;
  assign ins_valid = !fifo_empty;
  assign ins_op    = head.op;
  assign ins_imm   = head.imm;
  assign ins_pc    = head.pc;

  always_comb begin
    push           = 1'b0;
    push_entry     = '0;
    if (byte_acc) begin
      if (state == S_IMM) begin
        push           = 1'b1;
        push_entry.op  = held_op;
        push_entry.imm = in_byte;
        push_entry.pc  = held_pc;
      end else if (!in_byte[LONG_BIT]) begin
        push           = 1'b1;
        push_entry.op  = in_byte;
        push_entry.pc  = fetch_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= S_OP;
      held_op  <= '0;
      held_pc  <= '0;
      fetch_pc <= rst ? '0 : flush_pc;
    end else if (byte_acc) begin
      fetch_pc <= fetch_pc + 1'b1;
      case (state)
        S_OP: begin
          if (in_byte[LONG_BIT]) begin
            held_op <= in_byte;
            held_pc <= fetch_pc;
            state   <= S_IMM;
          end
        end
        S_IMM:   state <= S_OP;
        default: state <= S_OP;
      endcase
    end
  end

  tiny_cpu_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level_unused)
  );

`ifdef TINY_CPU_FETCH_STATS_EN
  // pop already excludes flush/rst cycles, so discarded entries are never counted.
  always_ff @(posedge clk) begin
    if (rst)      ins_count <= '0;
    else if (pop) ins_count <= ins_count + 1'b1;
  end
`else
  assign ins_count = 16'h0000;
`endif

endmodule

// File: tb/tb_tiny_cpu_fetch.sv
// Self-checking bench for tiny_cpu_fetch: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based reference model.
module tb_tiny_cpu_fetch;

  localparam int DEPTH = 4;
  localparam int PC_W  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      in_byte = 8'h00;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            flush = 1'b0;
  logic [PC_W-1:0] flush_pc = '0;
  logic [PC_W-1:0] fetch_pc;
  logic [7:0]      ins_op;
  logic [7:0]      ins_imm;
  logic [PC_W-1:0] ins_pc;
  logic            ins_valid;
  logic            ins_ready = 1'b0;
  logic [15:0]     ins_count;

  tiny_cpu_fetch #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .fetch_pc  (fetch_pc),
    .ins_op    (ins_op),
    .ins_imm   (ins_imm),
    .ins_pc    (ins_pc),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .ins_count (ins_count)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: instruction queue plus pending-opcode bookkeeping.
  typedef struct {
    logic [7:0] op;
    logic [7:0] imm;
    logic [7:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [7:0]  mpc = '0;
  bit          pend = 0;
  logic [7:0]  hop = '0;
  logic [7:0]  hpc = '0;
  logic [15:0] mcount = '0;
  bit          checking = 0;

  always @(posedge clk) begin : model
    int   sz;
    bit   acc;
    ent_t e;
    sz = q.size();
    if (rst) begin
      q.delete();
      mpc    = '0;
      pend   = 0;
      mcount = '0;
    end else if (flush) begin
      q.delete();
      mpc  = flush_pc;
      pend = 0;
    end else begin
      acc = in_valid && (sz < DEPTH);
      if (ins_ready && sz > 0) begin
        void'(q.pop_front());
        mcount = mcount + 16'd1;
      end
      if (acc) begin
        if (pend) begin
          e.op = hop; e.imm = in_byte; e.pc = hpc;
          q.push_back(e);
          pend = 0;
        end else if (in_byte >= 8'h80) begin
          hop  = in_byte;
          hpc  = mpc;
          pend = 1;
        end else begin
          e.op = in_byte; e.imm = 8'h00; e.pc = mpc;
          q.push_back(e);
        end
        mpc = mpc + 8'd1;
      end
    end
    checking = 1;
  end

  initial begin : compare
    logic [7:0]  e_op, e_imm, e_pc;
    logic [15:0] e_cnt;
    forever begin
      @(negedge clk);
      #2;
      if (checking) begin
        if (q.size() > 0) begin
          e_op = q[0].op; e_imm = q[0].imm; e_pc = q[0].pc;
        end else begin
          e_op = '0; e_imm = '0; e_pc = '0;
        end
`ifdef TINY_CPU_FETCH_STATS_EN
        e_cnt = mcount;
`else
        e_cnt = 16'h0000;
`endif
        chk("in_ready",  {15'd0, in_ready},  {15'd0, (!rst && !flush && q.size() < DEPTH)});
        chk("ins_valid", {15'd0, ins_valid}, {15'd0, (q.size() > 0)});
        chk("fetch_pc",  {8'd0, fetch_pc},   {8'd0, mpc});
        chk("ins_op",    {8'd0, ins_op},     {8'd0, e_op});
        chk("ins_imm",   {8'd0, ins_imm},    {8'd0, e_imm});
        chk("ins_pc",    {8'd0, ins_pc},     {8'd0, e_pc});
        chk("ins_count", ins_count,          e_cnt);
      end
    end
  end

  task automatic cyc(input logic v, input logic [7:0] b, input logic rdy,
                     input logic fl = 1'b0, input logic [7:0] fpc = 8'h00,
                     input logic r = 1'b0);
    @(negedge clk);
    in_valid  = v;
    in_byte   = b;
    ins_ready = rdy;
    flush     = fl;
    flush_pc  = fpc;
    rst       = r;
  endtask

  initial begin : stim
    int thr;
    logic [15:0] exp_cnt;

    // Reset values and one-byte sequence
    cyc(0, 8'h00, 0, 0, 8'h00, 1);
    cyc(1, 8'h01, 1); #1;
    chk("rst_fetch_pc", {8'd0, fetch_pc}, 16'h0000);
    chk("rst_valid",    {15'd0, ins_valid}, 16'h0000);
    chk("rst_in_ready", {15'd0, in_ready}, 16'h0001);
    chk("rst_count",    ins_count, 16'h0000);
    chk("rst_op",       {8'd0, ins_op}, 16'h0000);
    cyc(1, 8'h02, 1); #1;
    chk("seq1_op", {8'd0, ins_op}, 16'h0001);
    chk("seq1_pc", {8'd0, ins_pc}, 16'h0000);
    cyc(1, 8'h03, 1); #1;
    chk("seq2_op", {8'd0, ins_op}, 16'h0002);
    chk("seq2_pc", {8'd0, ins_pc}, 16'h0001);
    cyc(0, 8'h00, 1); #1;
    chk("seq3_op",  {8'd0, ins_op},  16'h0003);
    chk("seq3_imm", {8'd0, ins_imm}, 16'h0000);
    chk("seq3_pc",  {8'd0, ins_pc},  16'h0002);
    cyc(0, 8'h00, 0); #1;
    chk("seq_drained", {15'd0, ins_valid}, 16'h0000);
    chk("seq_fetch_pc", {8'd0, fetch_pc}, 16'h0003);

    // Two-byte instruction
    cyc(0, 8'h00, 0, 0, 8'h00, 1);
    cyc(1, 8'h85, 0);
    cyc(1, 8'h3C, 0); #1;
    chk("long_no_early", {15'd0, ins_valid}, 16'h0000);
    cyc(0, 8'h00, 0); #1;
    chk("long_op",  {8'd0, ins_op},   16'h0085);
    chk("long_imm", {8'd0, ins_imm},  16'h003C);
    chk("long_pc",  {8'd0, ins_pc},   16'h0000);
    chk("long_fpc", {8'd0, fetch_pc}, 16'h0002);
    cyc(0, 8'h00, 1);

    // Back-pressure with full FIFO and simultaneous pop
    cyc(0, 8'h00, 0, 0, 8'h00, 1);
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'h11 + 8'(i), 0);
    cyc(1, 8'h15, 1); #1;
    chk("full_in_ready", {15'd0, in_ready}, 16'h0000);
    chk("full_head",     {8'd0, ins_op},    16'h0011);
    cyc(1, 8'h15, 0); #1;
    chk("freed_in_ready", {15'd0, in_ready}, 16'h0001);
    chk("freed_head",     {8'd0, ins_op},    16'h0012);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h00, 1); #1;
      chk("bp_order", {8'd0, ins_op}, 16'h0012 + 16'(i));
    end
    cyc(0, 8'h00, 0); #1;
    chk("bp_drained", {15'd0, ins_valid}, 16'h0000);

    // Flush while an opcode is held
    cyc(0, 8'h00, 0, 0, 8'h00, 1);
    cyc(1, 8'h01, 0);
    cyc(1, 8'h02, 0);
    cyc(1, 8'h90, 0);
    cyc(1, 8'h55, 1, 1, 8'h40); #1;
    chk("flush_in_ready", {15'd0, in_ready}, 16'h0000);
    cyc(1, 8'h07, 0); #1;
    chk("flush_valid", {15'd0, ins_valid}, 16'h0000);
    chk("flush_fpc",   {8'd0, fetch_pc},   16'h0040);
    cyc(0, 8'h00, 0); #1;
    chk("post_flush_op",  {8'd0, ins_op},  16'h0007);
    chk("post_flush_imm", {8'd0, ins_imm}, 16'h0000);
    chk("post_flush_pc",  {8'd0, ins_pc},  16'h0040);

    // PC wraparound inside a two-byte instruction
    cyc(0, 8'h00, 1, 1, 8'hFF);
    cyc(1, 8'h81, 0);
    cyc(1, 8'h22, 0);
    cyc(0, 8'h00, 0); #1;
    chk("wrap_op",  {8'd0, ins_op},   16'h0081);
    chk("wrap_imm", {8'd0, ins_imm},  16'h0022);
    chk("wrap_pc",  {8'd0, ins_pc},   16'h00FF);
    chk("wrap_fpc", {8'd0, fetch_pc}, 16'h0001);

    // Stats: five transfers, then flush coincident with a pop
    cyc(0, 8'h00, 0, 0, 8'h00, 1);
    for (int i = 1; i <= 6; i++) cyc(1, 8'(i), 1);
    cyc(0, 8'h00, 1, 1, 8'h10);
    cyc(0, 8'h00, 1); #1;
`ifdef TINY_CPU_FETCH_STATS_EN
    exp_cnt = 16'd5;
`else
    exp_cnt = 16'd0;
`endif
    chk("stats_count", ins_count, exp_cnt);
    chk("stats_valid", {15'd0, ins_valid}, 16'h0000);

    // Randomized traffic with varying downstream back-pressure
    for (int ep = 0; ep < 6; ep++) begin
      case (ep % 3)
        0:       thr = 10;
        1:       thr = 50;
        default: thr = 90;
      endcase
      for (int n = 0; n < 500; n++) begin
        cyc(($urandom_range(0, 99) < 75), 8'($urandom),
            ($urandom_range(0, 99) < thr),
            ($urandom_range(0, 99) < 3), 8'($urandom),
            ($urandom_range(0, 399) < 1));
      end
    end

    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 1);
    @(negedge clk); #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
